// File: rtl/priority_encoder_pend_pkg.sv
// Shared definitions for the pending priority encoder.
//   PENC_MAX_N : largest supported request vector width
//   penc_w(n)  : index width needed to encode n lines
//   onehot()   : one-hot vector (PENC_MAX_N wide) with bit idx set
package priority_encoder_pkg;

  localparam int PENC_MAX_N = 64;

  function automatic int penc_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [PENC_MAX_N-1:0] onehot(input int idx, input int n);
    logic [PENC_MAX_N-1:0] v;
    v = '0;
    if (idx >= 0 && idx < n) v[idx[5:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/priority_encoder_pend_core.sv
// Combinational priority search over an N-bit vector.
//   i_vec   : candidate lines
//   i_ptr   : highest-priority line (only with PRIORITY_ENCODER_PEND_RR_EN)
//   o_idx   : selected line index
//   o_found : at least one candidate bit set
// Without PRIORITY_ENCODER_PEND_RR_EN the highest set index wins.
module priority_encoder_core
  import priority_encoder_pkg::*;
#(
  parameter int N = 16,
  parameter int W = penc_w(N)
) (
  input  logic [N-1:0] i_vec,
`ifdef PRIORITY_ENCODER_PEND_RR_EN
  input  logic [W-1:0] i_ptr,
`endif
  output logic [W-1:0] o_idx,
  output logic         o_found
);

  // Walk from lowest to highest priority; the last hit wins.
  always_comb begin
    o_idx = '0;
`ifdef PRIORITY_ENCODER_PEND_RR_EN
    // Lowest priority is ptr+1, highest is ptr, wrapping through 0.
    for (int k = 0; k < N; k++) begin
      int p;
      p = (int'(i_ptr) + 1 + k) % N;
      if (i_vec[p]) o_idx = W'(p);
    end
`else
    for (int k = 0; k < N; k++) begin
      if (i_vec[k]) o_idx = W'(k);
    end
`endif
  end

  assign o_found = |i_vec;

endmodule

// File: rtl/priority_encoder_pend.sv
// Registered N-input priority encoder with sticky pending capture.
//   clk, rst : clock, async active-high reset
//   req      : request events, OR'd into pend each edge
//   mask     : 1 excludes a line from selection (pend bit kept)
//   ready    : consumer accepts idx when valid
//   valid    : idx holds a pending line awaiting acceptance
//   idx      : presented line index
//   pend     : pending register readback
// Define PRIORITY_ENCODER_PEND_RR_EN for rotating priority.
module priority_encoder_pend
  import priority_encoder_pkg::*;
#(
  parameter int N = 16,
  parameter int W = penc_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] idx,
  output logic [N-1:0] pend
);

  logic [N-1:0]          r_pend;
  logic                  r_valid;
  logic [W-1:0]          r_idx;
  logic                  w_acc;
  logic [PENC_MAX_N-1:0] w_oh;
  logic [N-1:0]          w_clr;
  logic [N-1:0]          w_cand;
  logic [W-1:0]          w_sel;
  logic                  w_found;

  assign w_acc  = r_valid & ready;
  assign w_oh   = onehot(int'(r_idx), N);
  assign w_clr  = w_acc ? w_oh[N-1:0] : '0;
  // The line being accepted this edge must not be re-presented at once.
  assign w_cand = r_pend & ~mask & ~w_clr;

`ifdef PRIORITY_ENCODER_PEND_RR_EN
  logic [W-1:0] r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_ptr <= W'(N-1);
    else if (w_acc) r_ptr <= (r_idx == '0) ? W'(N-1) : r_idx - 1'b1;
  end

  priority_encoder_core #(.N(N), .W(W)) u_core (
    .i_vec   (w_cand),
    .i_ptr   (r_ptr),
    .o_idx   (w_sel),
    .o_found (w_found)
  );
`else
  priority_encoder_core #(.N(N), .W(W)) u_core (
    .i_vec   (w_cand),
    .o_idx   (w_sel),
    .o_found (w_found)
  );
`endif

  // Set wins over clear: a re-request on the accepted line re-pends it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pend <= '0;
    else     r_pend <= (r_pend & ~w_clr) | req;
  end

  // Output stage holds while valid && !ready; idx keeps its value when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
    end else if (!r_valid || ready) begin
      r_valid <= w_found;
      if (w_found) r_idx <= w_sel;
    end
  end

  assign valid = r_valid;
  assign idx   = r_idx;
  assign pend  = r_pend;

endmodule

// File: tb/tb_priority_encoder_pend.sv
module tb_priority_encoder_pend;
  import priority_encoder_pkg::*;

  localparam int N = 16;
  localparam int W = $clog2(N);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] mask = '0;
  logic         ready = 1'b0;
  logic         valid;
  logic [W-1:0] idx;
  logic [N-1:0] pend;

  priority_encoder_pend #(.N(N)) dut (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .ready(ready),
    .valid(valid), .idx(idx), .pend(pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    int           i;
    logic [N-1:0] p;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  // Reference state: pending set, presented grant, rotation pointer.
  logic [N-1:0] m_pend;
  logic         m_valid;
  int           m_idx;
  int           m_ptr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // First candidate found when scanning downward from ptr with wrap.
  function automatic int pick(input logic [N-1:0] c, input int ptr);
    for (int k = 0; k < N; k++) begin
      int l;
      l = (ptr - k + N) % N;
      if (c[l]) return l;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_valid = 1'b0; m_idx = 0; m_ptr = N - 1;
  endtask

  // Apply inputs for one edge and push the state expected after it.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] mk, input logic rd);
    exp_t e;
    logic [N-1:0] c, np;
    bit acc;
    int s;
    @(posedge clk); #2;
    req = r; mask = mk; ready = rd;
    acc = m_valid && rd;
    c  = m_pend & ~mk;
    np = m_pend;
    if (acc) begin
      c[m_idx]  = 1'b0;
      np[m_idx] = 1'b0;
    end
    np = np | r;
    s = pick(c, m_ptr);
`ifdef PRIORITY_ENCODER_PEND_RR_EN
    if (acc) m_ptr = (m_idx == 0) ? N - 1 : m_idx - 1;
`endif
    if (!m_valid || rd) begin
      m_valid = (s >= 0);
      if (s >= 0) m_idx = s;
    end
    m_pend = np;
    e.v = m_valid; e.i = m_idx; e.p = m_pend;
    sbq.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1; req = '0;
    #1;
    chk("async_rst_valid", 64'(valid), 64'd0);
    chk("async_rst_idx",   64'(idx),   64'd0);
    chk("async_rst_pend",  64'(pend),  64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: pops one expectation per edge while the scoreboard has any.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        chk("valid", 64'(valid), 64'(e.v));
        chk("idx",   64'(idx),   64'(e.i));
        chk("pend",  64'(pend),  64'(e.p));
      end
    end
  end

  initial begin
    model_reset();
    #1;
    chk("reset_valid", 64'(valid), 64'd0);
    chk("reset_idx",   64'(idx),   64'd0);
    chk("reset_pend",  64'(pend),  64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single event, held while not ready, then accepted.
    step(16'h0010, '0, 1'b0);
    for (int i = 0; i < 6; i++) step('0, '0, 1'b0);
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);

    // Fixed-priority drain of 0x8421.
    step(16'h8421, '0, 1'b1);
    for (int i = 0; i < 6; i++) step('0, '0, 1'b1);

    // Mask holds line 1 back, then releases it.
    step(16'h0003, 16'h0002, 1'b0);
    step('0, 16'h0002, 1'b0);
    step('0, 16'h0002, 1'b1);
    step('0, 16'h0002, 1'b1);
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);

    // Set-wins collision on line 7.
    step(16'h0080, '0, 1'b0);
    step('0, '0, 1'b0);
    step(16'h0080, '0, 1'b1);
    for (int i = 0; i < 4; i++) step('0, '0, 1'b1);

    // Higher-priority arrival while held is deferred.
    step(16'h0004, '0, 1'b0);
    step('0, '0, 1'b0);
    step(16'h4000, '0, 1'b0);
    step('0, '0, 1'b0);
    for (int i = 0; i < 4; i++) step('0, '0, 1'b1);

    // Alternating re-requests of lines 0 and 2 (rotates under RR).
    for (int i = 0; i < 8; i++) step(16'h0005, '0, 1'b1);
    for (int i = 0; i < 4; i++) step('0, '0, 1'b1);

    // Reset mid-operation with everything pending.
    step(16'hFFFF, '0, 1'b0);
    step('0, '0, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) step('0, '0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r, mk;
      logic rd;
      r  = N'($urandom & $urandom & $urandom);
      mk = N'($urandom & $urandom);
      rd = ($urandom_range(0, 3) != 0);
      step(r, mk, rd);
      if (i == 200) do_reset();
    end
    for (int i = 0; i < 20; i++) step('0, '0, 1'b1);

    @(posedge clk); @(posedge clk); #2;
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
